// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin valid/ready grant among NREQ
// requesters, plus a clear sequence that zeroes NREGS registers after reset or on init_req.
module regfile_write_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREGS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_req,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rf_regwrite,
  output logic [ADDR_W-1:0]      rf_writereg,
  output logic [DATA_W-1:0]      rf_writedata,
  output logic [1:0]             grant_id,
  output logic                   init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [1:0]        r_rr_ptr;

  logic [2:0]        w_sum;
  logic [1:0]        w_idx;
  logic [1:0]        w_gidx;
  logic              w_found;
  logic              w_accept;
  logic [NREQ-1:0]   w_grant;

  // Walk the requesters starting at r_rr_ptr, wrapping mod NREQ; first valid wins.
  always_comb begin
    w_sum   = '0;
    w_idx   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      if (w_sum >= 3'(NREQ)) w_sum = w_sum - 3'(NREQ);
      w_idx = w_sum[1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    w_grant = '0;
    if (w_found) w_grant[w_gidx] = 1'b1;
    w_accept  = rst && (r_state == ST_RUN) && w_found;
    req_ready = w_accept ? w_grant : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_clr_cnt    <= '0;
      r_rr_ptr     <= '0;
      rf_regwrite  <= 1'b0;
      rf_writereg  <= '0;
      rf_writedata <= '0;
      grant_id     <= '0;
      init_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          init_done    <= 1'b0;
          rf_writedata <= '0;
          if (init_req) begin
            rf_regwrite <= 1'b0;
            r_clr_cnt   <= '0;
          end else begin
            rf_regwrite <= 1'b1;
            rf_writereg <= r_clr_cnt;
            if (r_clr_cnt == ADDR_W'(NREGS - 1)) begin
              r_state   <= ST_RUN;
              r_clr_cnt <= '0;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          rf_regwrite <= w_accept;
          if (w_accept) begin
            rf_writereg  <= req_addr[w_gidx*ADDR_W +: ADDR_W];
            rf_writedata <= req_data[w_gidx*DATA_W +: DATA_W];
            grant_id     <= w_gidx;
            r_rr_ptr     <= (w_gidx == 2'(NREQ - 1)) ? 2'd0 : w_gidx + 2'd1;
          end
          // An accept in the same cycle still issues; the clears follow it.
          if (init_req) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            init_done <= 1'b0;
          end else begin
            init_done <= 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every issued register-file write.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        init_req;
  logic [2:0]  req_valid;
  logic [8:0]  req_addr;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_regwrite;
  logic [2:0]  rf_writereg;
  logic [15:0] rf_writedata;
  logic [1:0]  grant_id;
  logic        init_done;

  regfile_write_arbiter #(.NREQ(3), .DATA_W(16), .ADDR_W(3), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .init_req(init_req),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg),
    .rf_writedata(rf_writedata), .grant_id(grant_id), .init_done(init_done)
  );

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
    logic [1:0]  id;
    logic        chk_id;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  logic [2:0]  addr_t[3] = '{3'd1, 3'd5, 3'd6};
  logic [15:0] data_t[3] = '{16'h1111, 16'hBEEF, 16'hC0DE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_clears();
    for (int k = 0; k < 8; k++) q.push_back('{a: 3'(k), d: 16'h0, id: 2'd0, chk_id: 1'b0});
  endtask

  // One cycle: drive valid, check the combinational grant, queue the write it implies.
  task automatic step(input logic [2:0] v, input logic [2:0] exp);
    req_valid = v;
    #1;
    chk("req_ready", {29'd0, req_ready}, {29'd0, exp});
    for (int i = 0; i < 3; i++)
      if (exp[i]) q.push_back('{a: addr_t[i], d: data_t[i], id: 2'(i), chk_id: 1'b1});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && rf_regwrite) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write reg=%0d data=%0h at %0t", rf_writereg, rf_writedata, $time);
      end else begin
        e = q.pop_front();
        if (rf_writereg !== e.a || rf_writedata !== e.d || (e.chk_id && grant_id !== e.id)) begin
          failures++;
          $display("FAIL write got reg=%0d data=%0h id=%0d expected reg=%0d data=%0h id=%0d at %0t",
                   rf_writereg, rf_writedata, grant_id, e.a, e.d, e.id, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    init_req = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*3 +: 3]   = addr_t[i];
      req_data[i*16 +: 16] = data_t[i];
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    req_valid = 3'b111;
    #1;
    chk("rst_ready", {29'd0, req_ready}, 32'd0);
    chk("rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    req_valid = '0;

    // 1: clear sequence after release
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_clears();
    for (int c = 0; c < 9; c++) begin
      chk("init_done_low", {31'd0, init_done}, 32'd0);
      step(3'b000, 3'b000);
    end
    chk("init_done_high", {31'd0, init_done}, 32'd1);

    // 2: single requester; then move rr_ptr to 0
    step(3'b010, 3'b010);
    step(3'b100, 3'b100);

    // 3: all valid, round robin from 0
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++) step(3'b111, 3'(1 << i));

    // 4: rr_ptr=1 with 101 -> 2 then 0, then idle
    step(3'b001, 3'b001);
    step(3'b101, 3'b100);
    step(3'b101, 3'b001);
    step(3'b000, 3'b000);

    // 5: init_req together with an accept of req0 (rr_ptr=1), req1 held through INIT
    init_req = 1'b1;
    step(3'b001, 3'b001);
    init_req = 1'b0;
    push_clears();
    for (int c = 0; c < 9; c++) begin
      chk("reinit_done_low", {31'd0, init_done}, 32'd0);
      if (c < 8) step(3'b010, 3'b000);
    end
    step(3'b010, 3'b010);
    chk("reinit_done_high", {31'd0, init_done}, 32'd1);

    // 6: async reset one cycle after an accept (rr_ptr=2 -> grant 0)
    step(3'b001, 3'b001);
    rst = 1'b0;
    #1;
    chk("midrst_regwrite", {31'd0, rf_regwrite}, 32'd0);
    chk("midrst_writereg", {29'd0, rf_writereg}, 32'd0);
    chk("midrst_writedata", {16'd0, rf_writedata}, 32'd0);
    chk("midrst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("midrst_ready", {29'd0, req_ready}, 32'd0);
    q.delete();
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_clears();
    for (int c = 0; c < 9; c++) step(3'b000, 3'b000);
    chk("rerun_done_high", {31'd0, init_done}, 32'd1);
    step(3'b011, 3'b001);
    repeat (3) step(3'b000, 3'b000);

    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
